execute_writeback_ctrl: RTL and testbench
=========================================

// Module: execute_writeback_ctrl
// PURPOSE
//  Execute-side consumer of the decode->execute pipeline register. Takes the execute_* bundle,
//  runs 1-cycle AU ops, multi-cycle MUL ops and memory-handshaked LSU ops, and drives stall
//  back to the decode->execute register while a multi-cycle op occupies execute.
//  Produces a registered writeback bundle for the register file.
// PARAMETERS
//  MUL_LATENCY  3   cycles a MUL op occupies execute (>=2)
// PORTS
//  clk                   in   1   clock, rising edge
//  rst_n                 in   1   asynchronous active-low reset
//  operand1_execute      in   32  AU/MUL src1; LSU effective address
//  operand2_execute      in   32  AU/MUL src2; LSU store data
//  reg_write_execute     in   1   op writes rd
//  rd_execute            in   5   destination register
//  execute_type_execute  in   5   op select within unit (see BEHAVIOUR)
//  au_execute            in   1   op is AU
//  mul_execute           in   1   op is MUL
//  lsu_execute           in   1   op is LSU
//  stall                 out  1   hold decode->execute register (combinational)
//  mem_req               out  1   memory request, held until mem_ack
//  mem_we                out  1   1=store, 0=load; valid with mem_req
//  mem_addr              out  32  = operand1_execute
//  mem_wdata             out  32  = operand2_execute
//  mem_ack               in   1   memory done; may arrive same cycle as mem_req
//  mem_rdata             in   32  load data, valid with mem_ack
//  reg_write_writeback   out  1   registered write enable
//  rd_writeback          out  5   registered destination
//  result_writeback      out  32  registered result
// BEHAVIOUR
//  - Reset: state IDLE, counter 0, reg_write_writeback/rd_writeback/result_writeback 0; stall,
//    mem_req, mem_we 0 (no unit flag asserted on reset). Reset mid-op abandons it, no writeback.
//  - At most one of au/mul/lsu_execute set; none set = bubble, reg_write_writeback<=0.
//  - AU types: 0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLL,6 SRL,7 SRA,8 SLT,9 SLTU (shift amt [4:0]);
//    other codes -> result 0. stall=0. Writeback 1 cycle after op is in execute.
//  - MUL types: 0 MUL (low 32), 1 MULH (signed x signed, high 32), 2 MULHU (unsigned high 32),
//    3 MULHSU (signed x unsigned, high 32); others -> 0. 64-bit product internally.
//  - FSM: IDLE, MUL_BUSY, LSU_WAIT.
//    IDLE & mul_execute: capture operands/type/rd, cnt<=1, ->MUL_BUSY, stall=1.
//    MUL_BUSY: cnt++; done when cnt==MUL_LATENCY-1: stall=0, writeback at next edge, ->IDLE.
//    Op occupies execute exactly MUL_LATENCY cycles; stall high first MUL_LATENCY-1 of them.
//    IDLE/LSU_WAIT & lsu_execute: mem_req=1, mem_we=execute_type_execute[0] (0 LW,1 SW).
//    stall = lsu_execute & ~mem_ack. No ack -> ->LSU_WAIT (stay). Ack -> writeback next edge, ->IDLE.
//  - Back-to-back MUL/LSU: new op restarts from IDLE in the cycle after stall drops.
//  - Writeback: reg_write_writeback = reg_write & (rd!=0) & op not SW; rd 0 never written.
//    Load result = mem_rdata captured on mem_ack cycle.
//  - mem_ack outside an LSU op ignored. Operands are stable while stall=1 (upstream holds).
// TESTING
//  1 ADD 5+7 rd=3 -> stall 0; next cycle reg_write_writeback=1, rd=3, result 12.
//  2 MUL 6*7 rd=4, MUL_LATENCY=3 -> stall=1 for 2 cycles, result 42 cycle after stall drops.
//  3 MULH 0x80000000*2 -> 0xFFFFFFFF; MULHU same -> 0x00000001; SRA 0x80000000>>4 -> 0xF8000000.
//  4 LW addr 0x100, ack 3 cycles late, rdata 0xDEADBEEF -> mem_req/stall high until ack, then
//    result 0xDEADBEEF; same-cycle ack -> stall never rises.
//  5 SW addr 0x200 data 0x55 -> mem_we=1, mem_wdata 0x55; reg_write_writeback stays 0.
//  6 rst_n low mid-MUL -> state IDLE, stall 0, no writeback; ADD with rd=0 -> no write.

Source files
------------

// File: rtl/execute_writeback_ctrl.sv
// Execute stage controller: single-cycle AU ops, multi-cycle MUL ops and memory-handshaked
// LSU ops, with stall back to decode and a registered writeback bundle for the register file.
module execute_writeback_ctrl #(
  parameter int MUL_LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] operand1_execute,
  input  logic [31:0] operand2_execute,
  input  logic        reg_write_execute,
  input  logic [4:0]  rd_execute,
  input  logic [4:0]  execute_type_execute,
  input  logic        au_execute,
  input  logic        mul_execute,
  input  logic        lsu_execute,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        reg_write_writeback,
  output logic [4:0]  rd_writeback,
  output logic [31:0] result_writeback
);

  typedef enum logic [1:0] {
    IDLE,
    MUL_BUSY,
    LSU_WAIT
  } state_t;

  localparam int CNT_W = $clog2(MUL_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LATENCY - 1);

  state_t state;
  state_t next_state;

  logic [CNT_W-1:0] cnt;
  logic [31:0]      mul_a;
  logic [31:0]      mul_b;
  logic [4:0]       mul_type;
  logic [4:0]       mul_rd;
  logic             mul_reg_write;

  logic             mul_start;
  logic             mul_done;
  logic             is_store;
  logic [4:0]       shamt;
  logic [31:0]      au_result;
  logic [31:0]      mul_result;
  logic             mul_a_signed;
  logic             mul_b_signed;
  logic signed [63:0] mul_a_ext;
  logic signed [63:0] mul_b_ext;
  logic signed [63:0] product;

  assign mem_addr  = operand1_execute;
  assign mem_wdata = operand2_execute;

  assign mul_start = (state == IDLE) && mul_execute;
  assign mul_done  = (state == MUL_BUSY) && (cnt == CNT_LAST);
  assign is_store  = execute_type_execute[0];
  assign shamt     = operand2_execute[4:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (mul_execute) begin
          next_state = MUL_BUSY;
        end else if (lsu_execute && !mem_ack) begin
          next_state = LSU_WAIT;
        end
      end
      MUL_BUSY: begin
        if (mul_done) begin
          next_state = IDLE;
        end
      end
      LSU_WAIT: begin
        if (!lsu_execute || mem_ack) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // The memory request mirrors the op in execute; an ack in the same cycle keeps stall low.
  always_comb begin
    stall   = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    case (state)
      IDLE: begin
        if (mul_execute) begin
          stall = 1'b1;
        end else if (lsu_execute) begin
          mem_req = 1'b1;
          mem_we  = is_store;
          stall   = !mem_ack;
        end
      end
      MUL_BUSY: begin
        stall = !mul_done;
      end
      LSU_WAIT: begin
        if (lsu_execute) begin
          mem_req = 1'b1;
          mem_we  = is_store;
          stall   = !mem_ack;
        end
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

  always_comb begin
    au_result = 32'd0;
    case (execute_type_execute)
      5'd0: au_result = operand1_execute + operand2_execute;
      5'd1: au_result = operand1_execute - operand2_execute;
      5'd2: au_result = operand1_execute & operand2_execute;
      5'd3: au_result = operand1_execute | operand2_execute;
      5'd4: au_result = operand1_execute ^ operand2_execute;
      5'd5: au_result = operand1_execute << shamt;
      5'd6: au_result = operand1_execute >> shamt;
      5'd7: au_result = $unsigned($signed(operand1_execute) >>> shamt);
      5'd8: au_result = {31'd0, $signed(operand1_execute) < $signed(operand2_execute)};
      5'd9: au_result = {31'd0, operand1_execute < operand2_execute};
      default: au_result = 32'd0;
    endcase
  end

  // One 64-bit signed multiplier serves all variants by choosing how each operand extends.
  assign mul_a_signed = (mul_type == 5'd1) || (mul_type == 5'd3);
  assign mul_b_signed = (mul_type == 5'd1);
  assign mul_a_ext    = {{32{mul_a_signed & mul_a[31]}}, mul_a};
  assign mul_b_ext    = {{32{mul_b_signed & mul_b[31]}}, mul_b};
  assign product      = mul_a_ext * mul_b_ext;

  always_comb begin
    mul_result = 32'd0;
    case (mul_type)
      5'd0:    mul_result = product[31:0];
      5'd1,
      5'd2,
      5'd3:    mul_result = product[63:32];
      default: mul_result = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      mul_a         <= 32'd0;
      mul_b         <= 32'd0;
      mul_type      <= 5'd0;
      mul_rd        <= 5'd0;
      mul_reg_write <= 1'b0;
    end else if (mul_start) begin
      cnt           <= CNT_W'(1);
      mul_a         <= operand1_execute;
      mul_b         <= operand2_execute;
      mul_type      <= execute_type_execute;
      mul_rd        <= rd_execute;
      mul_reg_write <= reg_write_execute;
    end else if (mul_done) begin
      cnt <= '0;
    end else if (state == MUL_BUSY) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Register x0 is never written, and stores never produce a register write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_writeback <= 1'b0;
      rd_writeback        <= 5'd0;
      result_writeback    <= 32'd0;
    end else if (mul_done) begin
      reg_write_writeback <= mul_reg_write && (mul_rd != 5'd0);
      rd_writeback        <= mul_rd;
      result_writeback    <= mul_result;
    end else if ((state == MUL_BUSY) || mul_start) begin
      reg_write_writeback <= 1'b0;
    end else if (lsu_execute) begin
      if (mem_ack) begin
        reg_write_writeback <= reg_write_execute && (rd_execute != 5'd0) && !is_store;
        rd_writeback        <= rd_execute;
        result_writeback    <= is_store ? 32'd0 : mem_rdata;
      end else begin
        reg_write_writeback <= 1'b0;
      end
    end else if (au_execute) begin
      reg_write_writeback <= reg_write_execute && (rd_execute != 5'd0);
      rd_writeback        <= rd_execute;
      result_writeback    <= au_result;
    end else begin
      reg_write_writeback <= 1'b0;
    end
  end

endmodule

// File: tb/tb_execute_writeback_ctrl.sv
// Self-checking bench for execute_writeback_ctrl: directed cases plus randomized AU/MUL/LSU
// streams compared against a behavioural model built on plain 64-bit arithmetic.
module tb_execute_writeback_ctrl;

  localparam int L = 3;

  logic        clk;
  logic        rst_n;
  logic [31:0] operand1_execute;
  logic [31:0] operand2_execute;
  logic        reg_write_execute;
  logic [4:0]  rd_execute;
  logic [4:0]  execute_type_execute;
  logic        au_execute;
  logic        mul_execute;
  logic        lsu_execute;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        reg_write_writeback;
  logic [4:0]  rd_writeback;
  logic [31:0] result_writeback;

  int checks = 0;
  int errors = 0;

  execute_writeback_ctrl #(.MUL_LATENCY(L)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .operand1_execute     (operand1_execute),
    .operand2_execute     (operand2_execute),
    .reg_write_execute    (reg_write_execute),
    .rd_execute           (rd_execute),
    .execute_type_execute (execute_type_execute),
    .au_execute           (au_execute),
    .mul_execute          (mul_execute),
    .lsu_execute          (lsu_execute),
    .stall                (stall),
    .mem_req              (mem_req),
    .mem_we               (mem_we),
    .mem_addr             (mem_addr),
    .mem_wdata            (mem_wdata),
    .mem_ack              (mem_ack),
    .mem_rdata            (mem_rdata),
    .reg_write_writeback  (reg_write_writeback),
    .rd_writeback         (rd_writeback),
    .result_writeback     (result_writeback)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] au_model(input logic [4:0] t, input logic [31:0] a,
                                           input logic [31:0] b);
    int          sa;
    int          sb;
    int unsigned sh;
    sa = a;
    sb = b;
    sh = b % 32;
    case (t)
      5'd0:    return a + b;
      5'd1:    return a - b;
      5'd2:    return a & b;
      5'd3:    return a | b;
      5'd4:    return a ^ b;
      5'd5:    return a << sh;
      6:       return a >> sh;
      5'd7:    return sa >>> sh;
      5'd8:    return (sa < sb) ? 32'd1 : 32'd0;
      5'd9:    return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] mul_model(input logic [4:0] t, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = a;
    ub = b;
    case (t)
      5'd0: begin p = ua * ub; return p[31:0]; end
      5'd1: begin p = sa * sb; return p[63:32]; end
      5'd2: begin p = ua * ub; return p[63:32]; end
      5'd3: begin p = sa * longint'(ub); return p[63:32]; end
      default: return 32'd0;
    endcase
  endfunction

  task automatic clear_op();
    au_execute           = 1'b0;
    mul_execute          = 1'b0;
    lsu_execute          = 1'b0;
    reg_write_execute    = 1'b0;
    rd_execute           = 5'd0;
    execute_type_execute = 5'd0;
    operand1_execute     = 32'd0;
    operand2_execute     = 32'd0;
    mem_ack              = 1'b0;
    mem_rdata            = 32'd0;
  endtask

  task automatic set_op(input logic au, input logic mul, input logic lsu, input logic [4:0] t,
                        input logic [31:0] a, input logic [31:0] b, input logic rw,
                        input logic [4:0] rd);
    au_execute           = au;
    mul_execute          = mul;
    lsu_execute          = lsu;
    execute_type_execute = t;
    operand1_execute     = a;
    operand2_execute     = b;
    reg_write_execute    = rw;
    rd_execute           = rd;
  endtask

  task automatic run_au(input logic [4:0] t, input logic [31:0] a, input logic [31:0] b,
                        input logic rw, input logic [4:0] rd, input logic [31:0] exp_result,
                        input logic ack_noise);
    logic exp_we;
    exp_we = rw && (rd != 5'd0);
    set_op(1'b1, 1'b0, 1'b0, t, a, b, rw, rd);
    mem_ack   = ack_noise;
    mem_rdata = $urandom;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL au_stall: got stall=%b mem_req=%b required 0/0", stall, mem_req);
    end
    @(posedge clk);
    #1;
    clear_op();
    checks++;
    if (reg_write_writeback !== exp_we) begin
      errors++;
      $display("[TB] FAIL au_we: type %0d rd %0d got %b required %b", t, rd,
               reg_write_writeback, exp_we);
    end
    if (exp_we) begin
      checks++;
      if (rd_writeback !== rd || result_writeback !== exp_result) begin
        errors++;
        $display("[TB] FAIL au_result: type %0d a=%h b=%h got rd=%0d res=%h required rd=%0d res=%h",
                 t, a, b, rd_writeback, result_writeback, rd, exp_result);
      end
    end
  endtask

  task automatic run_mul(input logic [4:0] t, input logic [31:0] a, input logic [31:0] b,
                         input logic rw, input logic [4:0] rd, input logic [31:0] exp_result);
    int   n;
    logic exp_we;
    exp_we = rw && (rd != 5'd0);
    set_op(1'b0, 1'b1, 1'b0, t, a, b, rw, rd);
    n = 0;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mul_memreq: got %b required 0", mem_req);
    end
    while (stall === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != L - 1) begin
      errors++;
      $display("[TB] FAIL mul_stall_cycles: got %0d required %0d", n, L - 1);
    end
    @(posedge clk);
    #1;
    clear_op();
    checks++;
    if (reg_write_writeback !== exp_we) begin
      errors++;
      $display("[TB] FAIL mul_we: rd %0d got %b required %b", rd, reg_write_writeback, exp_we);
    end
    if (exp_we) begin
      checks++;
      if (rd_writeback !== rd || result_writeback !== exp_result) begin
        errors++;
        $display("[TB] FAIL mul_result: type %0d a=%h b=%h got rd=%0d res=%h required rd=%0d res=%h",
                 t, a, b, rd_writeback, result_writeback, rd, exp_result);
      end
    end
  endtask

  task automatic run_lsu(input logic store, input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] rdata, input int delay, input logic rw,
                         input logic [4:0] rd);
    logic exp_we;
    exp_we = rw && (rd != 5'd0) && !store;
    set_op(1'b0, 1'b0, 1'b1, {4'd0, store}, addr, data, rw, rd);
    for (int c = 0; c <= delay; c++) begin
      mem_ack   = (c == delay);
      mem_rdata = (c == delay) ? rdata : $urandom;
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b1 || mem_we !== store || mem_addr !== addr || mem_wdata !== data) begin
        errors++;
        $display("[TB] FAIL lsu_req: got req=%b we=%b addr=%h wdata=%h required 1/%b/%h/%h",
                 mem_req, mem_we, mem_addr, mem_wdata, store, addr, data);
      end
      checks++;
      if (stall !== (c != delay)) begin
        errors++;
        $display("[TB] FAIL lsu_stall: cycle %0d of %0d got %b required %b", c, delay, stall,
                 (c != delay));
      end
      @(posedge clk);
      #1;
    end
    clear_op();
    checks++;
    if (reg_write_writeback !== exp_we) begin
      errors++;
      $display("[TB] FAIL lsu_we: store %b rd %0d got %b required %b", store, rd,
               reg_write_writeback, exp_we);
    end
    if (exp_we) begin
      checks++;
      if (rd_writeback !== rd || result_writeback !== rdata) begin
        errors++;
        $display("[TB] FAIL lsu_load: got rd=%0d res=%h required rd=%0d res=%h", rd_writeback,
                 result_writeback, rd, rdata);
      end
    end
  endtask

  task automatic test_reset();
    clear_op();
    rst_n = 1'b0;
    #3;
    checks++;
    if (reg_write_writeback !== 1'b0 || rd_writeback !== 5'd0 || result_writeback !== 32'd0 ||
        stall !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: got we=%b rd=%0d res=%h stall=%b req=%b mwe=%b required all 0",
               reg_write_writeback, rd_writeback, result_writeback, stall, mem_req, mem_we);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    run_au(5'd0, 32'd5, 32'd7, 1'b1, 5'd3, 32'd12, 1'b0);
    run_mul(5'd0, 32'd6, 32'd7, 1'b1, 5'd4, 32'd42);
    run_mul(5'd1, 32'h8000_0000, 32'd2, 1'b1, 5'd7, 32'hFFFF_FFFF);
    run_mul(5'd2, 32'h8000_0000, 32'd2, 1'b1, 5'd8, 32'h0000_0001);
    run_au(5'd7, 32'h8000_0000, 32'd4, 1'b1, 5'd9, 32'hF800_0000, 1'b0);
    run_lsu(1'b0, 32'h100, 32'd0, 32'hDEAD_BEEF, 3, 1'b1, 5'd10);
    run_lsu(1'b0, 32'h104, 32'd0, 32'hCAFE_F00D, 0, 1'b1, 5'd11);
    run_lsu(1'b1, 32'h200, 32'h55, 32'h1234_5678, 1, 1'b1, 5'd12);
    run_au(5'd0, 32'd1, 32'd1, 1'b1, 5'd0, 32'd2, 1'b0);
  endtask

  task automatic test_reset_mid_mul();
    set_op(1'b0, 1'b1, 1'b0, 5'd0, 32'd9, 32'd9, 1'b1, 5'd13);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    clear_op();
    #1;
    checks++;
    if (stall !== 1'b0 || reg_write_writeback !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_mul: got stall=%b we=%b req=%b required 0/0/0", stall,
               reg_write_writeback, mem_req);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < L; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (reg_write_writeback !== 1'b0 || stall !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_abandon: cycle %0d got we=%b stall=%b required 0/0", i,
                 reg_write_writeback, stall);
      end
    end
    run_mul(5'd0, 32'd3, 32'd5, 1'b1, 5'd14, 32'd15);
  endtask

  task automatic test_random_au();
    logic [4:0]  t;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    for (int i = 0; i < 40; i++) begin
      t  = 5'($urandom_range(0, 15));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      rd = 5'($urandom_range(0, 31));
      run_au(t, a, b, 1'($urandom_range(0, 7) != 0), rd, au_model(t, a, b),
             1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_random_mul();
    logic [4:0]  t;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 25; i++) begin
      t = 5'($urandom_range(0, 5));
      a = $urandom;
      b = $urandom;
      run_mul(t, a, b, 1'b1, 5'($urandom_range(1, 31)), mul_model(t, a, b));
    end
  endtask

  task automatic test_random_lsu();
    for (int i = 0; i < 25; i++) begin
      run_lsu(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, $urandom_range(0, 4),
              1'b1, 5'($urandom_range(0, 31)));
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  t;
    logic [31:0] a;
    logic [31:0] b;
    int          kind;
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 3);
      a    = $urandom;
      b    = $urandom;
      case (kind)
        0: begin
          t = 5'($urandom_range(0, 9));
          run_au(t, a, b, 1'b1, 5'($urandom_range(1, 31)), au_model(t, a, b), 1'b0);
        end
        1: begin
          t = 5'($urandom_range(0, 3));
          run_mul(t, a, b, 1'b1, 5'($urandom_range(1, 31)), mul_model(t, a, b));
        end
        2: begin
          run_lsu(1'($urandom_range(0, 1)), a, b, $urandom, $urandom_range(0, 3), 1'b1,
                  5'($urandom_range(1, 31)));
        end
        default: begin
          clear_op();
          mem_ack = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
          mem_ack = 1'b0;
          checks++;
          if (reg_write_writeback !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bubble_we: got %b required 0", reg_write_writeback);
          end
        end
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid_mul();
    test_random_au();
    test_random_mul();
    test_random_lsu();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
